serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder controller driving an external demux-based full adder, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for two's-complement subtraction.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_en,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_s_sh;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_done;

    logic             w_shift;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_sum_cat;

    always_comb begin
        w_b_load = op_b;
        w_c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            w_b_load = ~op_b;
            w_c_load = 1'b1;
        end
`endif
    end

    // The lowest sum bit is always shifted out before it is read, so only WIDTH-1 bits are stored.
    always_comb begin
        w_sum_cat = {fa_sum, r_s_sh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_s_sh   <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= op_a;
                        r_b_sh  <= w_b_load;
                        r_c     <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_s_sh <= w_sum_cat[WIDTH-1:1];
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_c    <= fa_carry;
                    if (r_cnt == LAST) begin
                        r_cnt    <= '0;
                        r_result <= w_sum_cat;
                        r_cout   <= fa_carry;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_shift = (r_state == SHIFT);
        busy    = w_shift;
        done    = r_done;
        result  = r_result;
        cout    = r_cout;
        fa_en   = w_shift;
        fa_x    = w_shift & r_a_sh[0];
        fa_y    = w_shift & r_b_sh[0];
        fa_ci   = w_shift & r_c;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder; models the external full adder behaviourally.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         fa_en;
    logic         fa_x;
    logic         fa_y;
    logic         fa_ci;
    logic         fa_sum;
    logic         fa_carry;

    int unsigned n_checks;
    int unsigned n_errors;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .fa_en    (fa_en),
        .fa_x     (fa_x),
        .fa_y     (fa_y),
        .fa_ci    (fa_ci),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry)
    );

    // Full adder gated by its enable input, as the demux-based adder behaves.
    always_comb begin
        fa_sum   = fa_en & (fa_x ^ fa_y ^ fa_ci);
        fa_carry = fa_en & ((fa_x & fa_y) | (fa_x & fa_ci) | (fa_y & fa_ci));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] er, input logic ec);
        int unsigned cyc;
        int unsigned busy_cyc;
        int unsigned changes;
        logic [W-1:0] prev;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        cin      = ~ci;
        cyc      = 0;
        busy_cyc = 0;
        changes  = 0;
        prev     = result;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            if (result !== prev) changes++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(W));
        check({tag, "_busy"}, 64'(busy_cyc), 64'(W));
        check({tag, "_hold"}, 64'(changes), 64'd0);
        check({tag, "_res"}, 64'({ec, er}), 64'({cout, result}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned cyc;
        int          d1;
        int          d2;
        int unsigned dcount;
        int unsigned bcount;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset", 64'({busy, done, result, cout, fa_en, fa_x, fa_y, fa_ci}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_add("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        do_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Bit trace for 0x01 + 0x01
        check("trace_idle", 64'({fa_en, fa_x, fa_y, fa_ci}), 64'd0);
        @(negedge clk);
        op_a  = 8'h01;
        op_b  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            check($sformatf("trace_b%0d", k), 64'({fa_en, fa_x, fa_y, fa_ci}),
                  64'({1'b1, k == 0, k == 0, k == 1}));
            @(posedge clk);
            #1;
        end
        check("trace_done", 64'({done, fa_en, fa_x, fa_y, fa_ci}), 64'b10000);
        check("trace_res", 64'({cout, result}), 64'h002);
        @(posedge clk);
        #1;

        // start held high: back-to-back acceptance, op_a changed mid-SHIFT
        @(negedge clk);
        op_a  = 8'h11;
        op_b  = 8'h22;
        cin   = 1'b0;
        start = 1'b1;
        cyc = 0;
        d1  = -1;
        d2  = -1;
        while (d2 < 0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) op_a = 8'hF0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = int'(cyc);
                    check("cont_res1", 64'({cout, result}), 64'h033);
                end else begin
                    d2 = int'(cyc);
                    start = 1'b0;
                    check("cont_res2", 64'({cout, result}), 64'h112);
                end
            end
        end
        start = 1'b0;
        check("cont_first", 64'(d1), 64'd9);
        check("cont_space", 64'(d2 - d1), 64'd10);
        repeat (2) @(posedge clk);
        #1;
        check("cont_idle", 64'({busy, done}), 64'd0);

        // rst mid-SHIFT
        @(negedge clk);
        op_a  = 8'hAA;
        op_b  = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst", 64'({busy, done, result, cout, fa_en, fa_x, fa_y, fa_ci}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        bcount = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("midrst_nodone", 64'({dcount, bcount}), 64'd0);
        do_add("add1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        do_add("sub1001", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        do_add("sub0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
